// File: rtl/wbubus_pkg.sv
// Shared definitions for the wbubus encoder/serializer/decoder chain, so every
// stage agrees on the state encoding and the idle codeword.
package wbubus_pkg;

    typedef enum logic {
        WBU_IDLE = 1'b0,
        WBU_SEND = 1'b1
    } wbu_state_t;

    localparam int          WBU_CHAR_W    = 6;
    localparam logic [35:0] WBU_IDLE_WORD = 36'h0_0000_0000;

endpackage

// File: rtl/wbu_serialize.sv
// Splits BW-bit codewords into 6-bit characters (MS first), inserting an idle word after a quiet period.
// First character 1 clock after load; i_busy freezes o_char/o_stb/o_idle, next word loads on the last accept.
module wbu_serialize
    import wbubus_pkg::*;
#(
    parameter int BW     = 36,
    parameter int LGIDLE = 20
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fifo_empty_n,
    input  logic [BW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_stb,
    output logic [5:0]    o_char,
    input  logic          i_busy,
    output logic          o_idle
);

    localparam int NCH = BW / WBU_CHAR_W;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    wbu_state_t          state_q, state_d;
    logic [BW-1:0]       sreg_q, sreg_d;
    logic [IW-1:0]       index_q, index_d;
    logic [LGIDLE-1:0]   idle_cnt_q, idle_cnt_d;
    logic                idle_q, idle_d;
    logic                accept;
    logic                load;
    logic                idle_load;

    assign accept    = (state_q == WBU_SEND) && !i_busy;
    assign load      = i_fifo_empty_n
                     && ((state_q == WBU_IDLE) || (accept && (index_q == '0)));
    // FIFO data wins over a saturated idle timer on the same clock.
    assign idle_load = (state_q == WBU_IDLE) && !i_fifo_empty_n && (&idle_cnt_q);

    assign o_fifo_rd = load && !i_reset;
    assign o_stb     = (state_q == WBU_SEND);
    assign o_char    = sreg_q[BW-1 -: WBU_CHAR_W];
    assign o_idle    = idle_q;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        index_d    = index_q;
        idle_cnt_d = idle_cnt_q;
        idle_d     = idle_q;

        if (load) begin
            state_d    = WBU_SEND;
            sreg_d     = i_fifo_data;
            index_d    = IW'(NCH - 1);
            idle_cnt_d = '0;
            idle_d     = 1'b0;
        end else if (idle_load) begin
            state_d    = WBU_SEND;
            sreg_d     = BW'(WBU_IDLE_WORD);
            index_d    = IW'(NCH - 1);
            idle_cnt_d = '0;
            idle_d     = 1'b1;
        end else begin
            if (accept) begin
                if (index_q == '0) begin
                    state_d = WBU_IDLE;
                    idle_d  = 1'b0;
                end else begin
                    sreg_d  = sreg_q << WBU_CHAR_W;
                    index_d = index_q - IW'(1);
                end
            end
            if (state_q == WBU_SEND)
                idle_cnt_d = '0;
            else if (!(&idle_cnt_q))
                idle_cnt_d = idle_cnt_q + LGIDLE'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WBU_IDLE;
            sreg_q     <= '0;
            index_q    <= '0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            index_q    <= index_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_wbu_serialize.sv
// Directed and random stimulus for wbu_serialize (BW=36, LGIDLE=4) against a
// character-queue reference model; inputs driven after posedge, outputs checked at negedge.
module tb_wbu_serialize;

    localparam int BW     = 36;
    localparam int LGIDLE = 4;
    localparam int SAT    = (1 << LGIDLE) - 1;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_fifo_empty_n;
    logic [BW-1:0] i_fifo_data;
    logic          o_fifo_rd;
    logic          o_stb;
    logic [5:0]    o_char;
    logic          i_busy;
    logic          o_idle;

    wbu_serialize #(.BW(BW), .LGIDLE(LGIDLE)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_fifo_empty_n (i_fifo_empty_n),
        .i_fifo_data    (i_fifo_data),
        .o_fifo_rd      (o_fifo_rd),
        .o_stb          (o_stb),
        .o_char         (o_char),
        .i_busy         (i_busy),
        .o_idle         (o_idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending FIFO words plus the characters still owed.
    logic [BW-1:0] fifo[$];
    logic [5:0]    mq[$];
    bit            m_send   = 1'b0;
    bit            m_idle   = 1'b0;
    bit            m_rstchr = 1'b1;
    int            m_cnt    = 0;

    // Characters seen on o_stb cycles, for the single-word table check.
    logic [5:0]    seen[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[BW-1:0];
    endfunction

    task automatic tick(input bit busy, input bit rst);
        bit            exp_rd;
        bit            was_send;
        logic [BW-1:0] w;
        i_reset        = rst;
        i_busy         = busy;
        i_fifo_empty_n = (fifo.size() > 0);
        i_fifo_data    = (fifo.size() > 0) ? fifo[0] : rand_word();
        @(negedge clk);
        exp_rd = !rst && (fifo.size() > 0) && (!m_send || (mq.size() == 1 && !busy));
        chk("fifo_rd", {63'd0, o_fifo_rd}, {63'd0, exp_rd});
        chk("stb",     {63'd0, o_stb},     {63'd0, m_send});
        chk("idle",    {63'd0, o_idle},    {63'd0, m_idle});
        if (m_send)
            chk("char", {58'd0, o_char}, {58'd0, mq[0]});
        else if (m_rstchr)
            chk("char_rst", {58'd0, o_char}, 64'd0);
        if (o_stb && !busy)
            seen.push_back(o_char);

        if (rst) begin
            m_send = 1'b0;
            m_idle = 1'b0;
            m_cnt  = 0;
            m_rstchr = 1'b1;
            mq.delete();
        end else begin
            was_send = m_send;
            if (exp_rd) begin
                w = fifo.pop_front();
                mq.delete();
                for (int k = 0; k < BW / 6; k++)
                    mq.push_back(w[BW-1-6*k -: 6]);
                m_send = 1'b1;
                m_idle = 1'b0;
                m_cnt  = 0;
                m_rstchr = 1'b0;
            end else if (!m_send && m_cnt == SAT) begin
                mq.delete();
                for (int k = 0; k < BW / 6; k++)
                    mq.push_back(6'd0);
                m_send = 1'b1;
                m_idle = 1'b1;
                m_cnt  = 0;
                m_rstchr = 1'b0;
            end else begin
                if (m_send && !busy) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        m_send = 1'b0;
                        m_idle = 1'b0;
                    end
                end
                if (was_send)
                    m_cnt = 0;
                else if (m_cnt < SAT)
                    m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_quiet(input int limit, input string tag);
        int n;
        n = 0;
        while ((m_send || fifo.size() > 0) && n < limit) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk(tag, {63'd0, (m_send || fifo.size() > 0)}, 64'd0);
    endtask

    initial begin
        logic [5:0] single_tbl[6];
        int         n;
        single_tbl = '{6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09};
        i_reset = 1'b1;
        i_busy = 1'b0;
        i_fifo_empty_n = 1'b0;
        i_fifo_data = '0;
        @(posedge clk);
        #1;

        // Reset state, then a single word with no backpressure.
        tick(1'b0, 1'b1);
        seen.delete();
        fifo.push_back(36'h123456789);
        run_until_quiet(20, "single_done");
        chk("single_count", seen.size(), 6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            chk("single_tbl", {58'd0, seen[k]}, {58'd0, single_tbl[k]});
        tick(1'b0, 1'b0);

        // Back-to-back words: second pop coincides with the sixth accept.
        fifo.push_back(rand_word());
        fifo.push_back(rand_word());
        run_until_quiet(30, "b2b_done");

        // Backpressure on the third character.
        fifo.push_back(rand_word());
        n = 0;
        while (!(m_send && mq.size() == 4) && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("bp_reach", {63'd0, (m_send && mq.size() == 4)}, 64'd1);
        repeat (5) tick(1'b1, 1'b0);
        run_until_quiet(20, "bp_done");

        // Idle insertion with an empty FIFO over several periods.
        tick(1'b0, 1'b1);
        repeat (70) tick(1'b0, 1'b0);

        // Collision: FIFO data lands exactly on the saturation clock.
        tick(1'b0, 1'b1);
        repeat (SAT) tick(1'b0, 1'b0);
        chk("coll_sat", m_cnt, SAT);
        fifo.push_back(rand_word());
        tick(1'b0, 1'b0);
        chk("coll_noidle", {63'd0, m_idle}, 64'd0);
        run_until_quiet(20, "coll_done");

        // Reset mid-word, then the next word restarts at its MS character.
        fifo.push_back(rand_word());
        fifo.push_back(rand_word());
        n = 0;
        while (!(m_send && mq.size() == 4) && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("rst_reach", {63'd0, (m_send && mq.size() == 4)}, 64'd1);
        tick(1'b0, 1'b1);
        run_until_quiet(30, "rst_done");

        // Random traffic, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (fifo.size() < 3 && $urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 4 : 1))
                fifo.push_back(rand_word());
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
